bin_to_onehot_pipe: RTL and testbench

Streaming binary-to-one-hot decoder. It is the inverse of the pooling filter's one-hot-to-binary encoder. It takes argmax/select indices as binary codes over a valid/ready stream and emits registered one-hot masks for the unpooling and mask-routing logic. A 2-entry output buffer absorbs downstream backpressure without losing throughput. Out-of-range indices are flagged and counted.

---
 rtl/bin_to_onehot_pipe.sv | 149 ++++++++++++++
 tb/tb_bin_to_onehot_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_onehot_pipe.sv
// ---------------------------------------------------------------------------
// bin_to_onehot_pipe
//
// Streaming binary-to-one-hot decoder. Binary indices arrive on a valid/ready
// stream. Each one is decoded when it is accepted, and the one-hot mask and
// its out-of-range flag go into a 2-entry output buffer. The buffer head
// drives the registered output stream. An index >= ONEHOT_W produces an
// all-zero mask with out_err set, and bumps a saturating error counter.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   in_valid    upstream index valid
//   in_ready    block can accept an index this cycle (registered state only)
//   in_bin      binary index, BIN_W bits
//   out_valid   head-of-buffer mask valid
//   out_ready   downstream accepts the head mask
//   out_onehot  decoded one-hot mask, ONEHOT_W bits (zero when not valid)
//   out_err     head entry came from an out-of-range index
//   err_count   saturating count of out-of-range indices accepted
// ---------------------------------------------------------------------------
module bin_to_onehot_pipe #(
  parameter int BIN_W    = 4,
  parameter int ONEHOT_W = 16,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic                out_err,
  output logic [CNT_W-1:0]    err_count
);

  // One buffered entry: the decoded mask and its out-of-range flag.
  typedef struct packed {
    logic                err;
    logic [ONEHOT_W-1:0] mask;
  } entry_t;

  // ONEHOT_W is at most 2**BIN_W, so it fits in BIN_W+1 bits.
  localparam logic [BIN_W:0]   LIMIT   = (BIN_W + 1)'(ONEHOT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam entry_t           EMPTY   = '{err: 1'b0, mask: {ONEHOT_W{1'b0}}};

  // Decode one index into a buffer entry. An out-of-range index gives an
  // all-zero mask with err set.
  function automatic entry_t decode(input logic [BIN_W-1:0] bin);
    entry_t e;
    e = EMPTY;
    if ({1'b0, bin} >= LIMIT) begin
      e.err = 1'b1;
    end else begin
      for (int i = 0; i < ONEHOT_W; i++) begin
        e.mask[i] = ({1'b0, bin} == (BIN_W + 1)'(i));
      end
    end
    return e;
  endfunction

  // head_q is always the oldest entry and tail_q the second one. A slot that
  // holds no entry is kept at EMPTY, so the outputs read zero while idle.
  logic [1:0]       count_q, count_d;
  logic             out_valid_q, out_valid_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic   accept_s;
  logic   pop_s;
  entry_t new_entry_s;

  assign in_ready   = (count_q < 2'd2) && !rst;
  assign out_valid  = out_valid_q;
  assign out_onehot = head_q.mask;
  assign out_err    = head_q.err;
  assign err_count  = err_count_q;

  // Handshakes, buffer next state and saturating error counter.
  always_comb begin
    accept_s    = in_valid && in_ready;
    pop_s       = out_valid_q && out_ready;
    new_entry_s = decode(in_bin);
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    err_count_d = err_count_q;

    case ({accept_s, pop_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = new_entry_s;
          count_d = 2'd1;
        end else begin
          tail_d  = new_entry_s;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d  = tail_q;
          tail_d  = EMPTY;
          count_d = 2'd1;
        end else begin
          head_d  = EMPTY;
          count_d = 2'd0;
        end
      end
      2'b11: begin
        // Only reachable at count 1: the head leaves and the new entry
        // replaces it, so the count stays at 1.
        head_d = new_entry_s;
      end
      default: begin
        count_d = count_q;
      end
    endcase

    if (accept_s && new_entry_s.err && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_count_d = err_count_q;
    end

    out_valid_d = (count_d != 2'd0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 2'd0;
      out_valid_q <= 1'b0;
      head_q      <= EMPTY;
      tail_q      <= EMPTY;
      err_count_q <= {CNT_W{1'b0}};
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_bin_to_onehot_pipe.sv
// ---------------------------------------------------------------------------
// tb_bin_to_onehot_pipe
//
// Self-checking bench for bin_to_onehot_pipe. Instance A is the full-range
// decoder (BIN_W=4, ONEHOT_W=16) and instance B is a narrow decoder
// (ONEHOT_W=10) that exercises the out-of-range path. The two instances share
// clk and rst. Each scenario task drives its own stimulus and compares the
// outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_bin_to_onehot_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [3:0]  a_in_bin   = 4'd0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [15:0] a_out_onehot;
  logic        a_out_err;
  logic [7:0]  a_err_count;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [3:0]  b_in_bin   = 4'd0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [9:0]  b_out_onehot;
  logic        b_out_err;
  logic [7:0]  b_err_count;

  int tests_run    = 0;
  int tests_failed = 0;

  bin_to_onehot_pipe #(.BIN_W(4), .ONEHOT_W(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bin(a_in_bin),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_onehot(a_out_onehot), .out_err(a_out_err), .err_count(a_err_count)
  );

  bin_to_onehot_pipe #(.BIN_W(4), .ONEHOT_W(10), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_onehot(b_out_onehot), .out_err(b_out_err), .err_count(b_err_count)
  );

  // Reference one-hot-to-binary encoder: returns the index of the single set
  // bit, or -1 if the mask is not exactly one-hot.
  function automatic int encode16(input logic [15:0] oh);
    int idx;
    int ones;
    idx  = -1;
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) begin
        idx  = i;
        ones = ones + 1;
      end
    end
    if (ones != 1) idx = -1;
    return idx;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests_run++;
    if (a_out_valid !== 1'b0 || a_out_onehot !== 16'h0000 || a_out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: valid=%b onehot=%h err=%b, required 0/0000/0", a_out_valid, a_out_onehot, a_out_err);
    end
    tests_run++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready: a=%b b=%b, required 0/0", a_in_ready, b_in_ready);
    end
    tests_run++;
    if (a_err_count !== 8'd0 || b_err_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_err_count: a=%0d b=%0d, required 0/0", a_err_count, b_err_count);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: a=%b b=%b, required 1/1", a_in_ready, b_in_ready);
    end
    step();
  endtask

  task automatic test_stream();
    logic [15:0] exp;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_bin    = 4'd0;
    for (int k = 0; k < 16; k++) begin
      step();
      exp = 16'h0001 << k;
      tests_run++;
      if (a_out_valid !== 1'b1 || a_out_onehot !== exp || a_out_err !== 1'b0 || a_in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_k%0d: valid=%b onehot=%h err=%b in_ready=%b, required 1/%h/0/1",
                 k, a_out_valid, a_out_onehot, a_out_err, a_in_ready, exp);
      end
      if (k < 15) begin
        a_in_bin = 4'(k + 1);
      end else begin
        a_in_valid = 1'b0;
      end
    end
    step();
    tests_run++;
    if (a_out_valid !== 1'b0 || a_out_onehot !== 16'h0000 || a_err_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL stream_drain: valid=%b onehot=%h err_count=%0d, required 0/0000/0",
               a_out_valid, a_out_onehot, a_err_count);
    end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_bin    = 4'd3;
    step();
    a_in_bin = 4'd7;
    step();
    a_in_valid = 1'b0;
    tests_run++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_onehot !== 16'h0008) begin
      tests_failed++;
      $display("FAIL bp_full: in_ready=%b valid=%b onehot=%h, required 0/1/0008", a_in_ready, a_out_valid, a_out_onehot);
    end
    step();
    tests_run++;
    if (a_in_ready !== 1'b0 || a_out_onehot !== 16'h0008) begin
      tests_failed++;
      $display("FAIL bp_hold: in_ready=%b onehot=%h, required 0/0008", a_in_ready, a_out_onehot);
    end
    a_out_ready = 1'b1;
    #1;
    tests_run++;
    if (a_in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_no_comb_path: in_ready=%b, required 0", a_in_ready);
    end
    step();
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_onehot !== 16'h0080 || a_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_second: valid=%b onehot=%h in_ready=%b, required 1/0080/1", a_out_valid, a_out_onehot, a_in_ready);
    end
    step();
    tests_run++;
    if (a_out_valid !== 1'b0 || a_out_onehot !== 16'h0000 || a_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_empty: valid=%b onehot=%h in_ready=%b, required 0/0000/1", a_out_valid, a_out_onehot, a_in_ready);
    end
  endtask

  task automatic test_out_of_range();
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_bin    = 4'd12;
    step();
    tests_run++;
    if (b_out_valid !== 1'b1 || b_out_onehot !== 10'h000 || b_out_err !== 1'b1 || b_err_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL oor_12: valid=%b onehot=%h err=%b err_count=%0d, required 1/000/1/1",
               b_out_valid, b_out_onehot, b_out_err, b_err_count);
    end
    b_in_bin = 4'd9;
    step();
    tests_run++;
    if (b_out_onehot !== 10'h200 || b_out_err !== 1'b0 || b_err_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL oor_msb_9: onehot=%h err=%b err_count=%0d, required 200/0/1", b_out_onehot, b_out_err, b_err_count);
    end
    b_in_bin = 4'd15;
    for (int i = 0; i < 253; i++) step();
    tests_run++;
    if (b_err_count !== 8'd254 || b_out_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_count_254: err_count=%0d err=%b, required 254/1", b_err_count, b_out_err);
    end
    for (int i = 0; i < 47; i++) step();
    tests_run++;
    if (b_err_count !== 8'd255) begin
      tests_failed++;
      $display("FAIL oor_saturate: err_count=%0d, required 255", b_err_count);
    end
    b_in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_bin    = 4'd1;
    step();
    a_in_bin = 4'd2;
    step();
    a_in_valid = 1'b0;
    tests_run++;
    if (a_in_ready !== 1'b0 || a_out_onehot !== 16'h0002) begin
      tests_failed++;
      $display("FAIL rmid_full: in_ready=%b onehot=%h, required 0/0002", a_in_ready, a_out_onehot);
    end
    rst        = 1'b1;
    a_in_valid = 1'b1;
    a_in_bin   = 4'd4;
    b_in_valid = 1'b1;
    b_in_bin   = 4'd12;
    #1;
    tests_run++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_ready_in_rst: a=%b b=%b, required 0/0", a_in_ready, b_in_ready);
    end
    step();
    tests_run++;
    if (a_out_valid !== 1'b0 || a_out_onehot !== 16'h0000 || a_out_err !== 1'b0 || b_err_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL rmid_cleared: valid=%b onehot=%h err=%b b_err_count=%0d, required 0/0000/0/0",
               a_out_valid, a_out_onehot, a_out_err, b_err_count);
    end
    rst        = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    #1;
    tests_run++;
    if (a_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_ready_after: in_ready=%b, required 1", a_in_ready);
    end
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (a_out_valid !== 1'b0 || a_out_onehot !== 16'h0000 || b_err_count !== 8'd0) begin
        tests_failed++;
        $display("FAIL rmid_no_stale_%0d: valid=%b onehot=%h b_err_count=%0d, required 0/0000/0",
                 i, a_out_valid, a_out_onehot, b_err_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_bin    = 4'd1;
    step();
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_onehot !== 16'h0002) begin
      tests_failed++;
      $display("FAIL b2b_head: valid=%b onehot=%h, required 1/0002", a_out_valid, a_out_onehot);
    end
    a_in_bin    = 4'd5;
    a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_onehot !== 16'h0020 || a_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_replace: valid=%b onehot=%h in_ready=%b, required 1/0020/1", a_out_valid, a_out_onehot, a_in_ready);
    end
    step();
    tests_run++;
    if (a_out_valid !== 1'b0 || a_out_onehot !== 16'h0000) begin
      tests_failed++;
      $display("FAIL b2b_count1: valid=%b onehot=%h, required 0/0000", a_out_valid, a_out_onehot);
    end
  endtask

  task automatic test_round_trip();
    int q[$];
    int got;
    int popped;
    logic acc;
    logic pop;
    popped = 0;
    for (int c = 0; c < 304; c++) begin
      if (c < 300) begin
        a_in_valid  = ($urandom_range(0, 3) != 0);
        a_in_bin    = 4'($urandom_range(0, 15));
        a_out_ready = ($urandom_range(0, 1) == 1);
      end else begin
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
      end
      #1;
      tests_run++;
      if (a_out_valid !== (q.size() != 0)) begin
        tests_failed++;
        $display("FAIL rt_valid_c%0d: valid=%b, required %b", c, a_out_valid, (q.size() != 0));
      end
      acc = a_in_valid && a_in_ready;
      pop = a_out_valid && a_out_ready;
      if (pop && q.size() != 0) begin
        got = encode16(a_out_onehot);
        tests_run++;
        if (got != q[0] || a_out_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL rt_index_%0d: recovered=%0d err=%b, required %0d/0", popped, got, a_out_err, q[0]);
        end
        void'(q.pop_front());
        popped++;
      end
      if (acc) q.push_back(int'(a_in_bin));
      step();
    end
    tests_run++;
    if (q.size() != 0 || a_out_valid !== 1'b0 || popped < 50) begin
      tests_failed++;
      $display("FAIL rt_drain: left=%0d valid=%b popped=%0d, required 0/0/>=50", q.size(), a_out_valid, popped);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
